// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Optional parity feature in the top is enabled with SHARED_REG_PARITY_EN.
package shared_reg_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam int DEF_NREQ = 4;
  localparam int IDX_W    = $clog2(DEF_NREQ);

  // Reference round-robin pick for up to 8 requesters: first set bit at or above ptr, wrapping
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] win;
    logic       hit;
    int         j;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (!hit && req[j]) begin
          win = 3'(j);
          hit = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: rotate req by ptr, pick lowest set bit, map back.
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            found,
  output logic [IW-1:0]   idx
);

  logic [NREQ-1:0] rot;
  int              pos;
  int              j;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = i + int'(ptr);
      if (j >= NREQ) j = j - NREQ;
      rot[i] = req[j];
    end
    found = |rot;
    pos   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = i;
    end
    pos = pos + int'(ptr);
    if (pos >= NREQ) pos = pos - NREQ;
    idx = IW'(pos);
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one register among NREQ writers, with a post-write HOLD window.
// Define SHARED_REG_PARITY_EN to add q_par / chk_en / par_err parity checking.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    q_valid,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
`ifdef SHARED_REG_PARITY_EN
  ,
  output logic                    q_par,
  input  logic                    chk_en,
  output logic                    par_err
`endif
);

  localparam int IW = $clog2(NREQ);

  shared_reg_pkg::state_t state;
  logic [3:0]             cnt;
  logic [IW-1:0]          ptr;
  logic                   found;
  logic [IW-1:0]          win;
  logic [WIDTH-1:0]       win_data;

  rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (win)
  );

  assign win_data = wdata[win*WIDTH +: WIDTH];

  // Single FSM: capture, grant pulse and HOLD countdown
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= shared_reg_pkg::IDLE;
      cnt     <= '0;
      ptr     <= '0;
      q       <= '0;
      gnt     <= '0;
      q_valid <= 1'b0;
      owner   <= '0;
      busy    <= 1'b0;
    end else begin
      gnt     <= '0;
      q_valid <= 1'b0;
      case (state)
        shared_reg_pkg::IDLE: begin
          if (found) begin
            q       <= win_data;
            gnt     <= NREQ'(1) << win;
            q_valid <= 1'b1;
            owner   <= win;
            ptr     <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
            if (HOLD > 0) begin
              state <= shared_reg_pkg::HOLD;
              cnt   <= 4'(HOLD);
              busy  <= 1'b1;
            end
          end
        end
        shared_reg_pkg::HOLD: begin
          if (cnt == 4'd1) begin
            state <= shared_reg_pkg::IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= shared_reg_pkg::IDLE;
      endcase
    end
  end

`ifdef SHARED_REG_PARITY_EN
  // Parity tracks q; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      q_par   <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (state == shared_reg_pkg::IDLE && found) q_par <= ^win_data;
      if (chk_en && ((^q) != q_par)) par_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: one HOLD=2 instance and one HOLD=0 instance.
module tb_shared_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req2 = '0, req0 = '0;
  logic [31:0] wd2 = '0, wd0 = '0;
  logic [3:0]  gnt2, gnt0;
  logic [7:0]  q2, q0;
  logic        qv2, qv0, busy2, busy0;
  logic [1:0]  own2, own0;
  int          checks = 0;
  int          errors = 0;
`ifdef SHARED_REG_PARITY_EN
  logic        qpar2, qpar0, perr2, perr0;
  logic        chk2 = 1'b0, chk0 = 1'b0;
`endif

  always #5 clk = ~clk;

  shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .req(req2), .wdata(wd2), .gnt(gnt2), .q(q2),
    .q_valid(qv2), .owner(own2), .busy(busy2)
`ifdef SHARED_REG_PARITY_EN
    , .q_par(qpar2), .chk_en(chk2), .par_err(perr2)
`endif
  );

  shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .HOLD(0)) u_h0 (
    .clk(clk), .rst(rst), .req(req0), .wdata(wd0), .gnt(gnt0), .q(q0),
    .q_valid(qv0), .owner(own0), .busy(busy0)
`ifdef SHARED_REG_PARITY_EN
    , .q_par(qpar0), .chk_en(chk0), .par_err(perr0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req2 = 4'b1111; req0 = 4'b1111;
    wd2 = 32'hFFEEDDCC; wd0 = 32'h44332211;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q2); end
      checks++; if (gnt2 !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt2); end
      checks++; if (qv2 !== 1'b0) begin errors++; $display("FAIL reset_qvalid got %b exp 0", qv2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy2); end
      checks++; if (own2 !== 2'd0) begin errors++; $display("FAIL reset_owner got %0d exp 0", own2); end
      checks++; if (gnt0 !== 4'b0000 || q0 !== 8'h00) begin errors++; $display("FAIL reset_h0 got gnt=%b q=%h exp 0000/00", gnt0, q0); end
    end
    req2 = '0; req0 = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_writer();
    wd2 = 32'h00A50000; req2 = 4'b0100;
    tick();
    req2 = '0;
    checks++; if (gnt2 !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", gnt2); end
    checks++; if (q2 !== 8'hA5) begin errors++; $display("FAIL single_q got %h exp a5", q2); end
    checks++; if (own2 !== 2'd2) begin errors++; $display("FAIL single_owner got %0d exp 2", own2); end
    checks++; if (qv2 !== 1'b1) begin errors++; $display("FAIL single_qvalid got %b exp 1", qv2); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", busy2); end
    tick();
    checks++; if (gnt2 !== 4'b0000 || qv2 !== 1'b0) begin errors++; $display("FAIL single_pulse got gnt=%b qv=%b exp 0000/0", gnt2, qv2); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b exp 1", busy2); end
    checks++; if (q2 !== 8'hA5) begin errors++; $display("FAIL single_qhold got %h exp a5", q2); end
    tick();
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b exp 0", busy2); end
  endtask

  task automatic test_wrap();
    // ptr is 3 after granting requester 2
    wd2 = 32'h00003130; req2 = 4'b0011;
    tick();
    req2 = 4'b0010;
    checks++; if (gnt2 !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0 got %b exp 0001", gnt2); end
    checks++; if (q2 !== 8'h30 || own2 !== 2'd0) begin errors++; $display("FAIL wrap_q0 got q=%h own=%0d exp 30/0", q2, own2); end
    tick(); tick();
    checks++; if (gnt2 !== 4'b0000) begin errors++; $display("FAIL wrap_gap got %b exp 0000", gnt2); end
    tick();
    req2 = '0;
    checks++; if (gnt2 !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1 got %b exp 0010", gnt2); end
    checks++; if (q2 !== 8'h31 || own2 !== 2'd1) begin errors++; $display("FAIL wrap_q1 got q=%h own=%0d exp 31/1", q2, own2); end
    tick(); tick();
  endtask

  task automatic test_hold_block();
    // ptr is 2; only requester 3 active so it wins
    wd2 = 32'h775A0000; req2 = 4'b1000;
    tick();
    checks++; if (gnt2 !== 4'b1000 || q2 !== 8'h77) begin errors++; $display("FAIL hold_first got gnt=%b q=%h exp 1000/77", gnt2, q2); end
    wd2 = 32'h77005A00; req2 = 4'b0010;
    tick();
    checks++; if (gnt2 !== 4'b0000 || q2 !== 8'h77) begin errors++; $display("FAIL hold_blk1 got gnt=%b q=%h exp 0000/77", gnt2, q2); end
    tick();
    checks++; if (gnt2 !== 4'b0000 || q2 !== 8'h77) begin errors++; $display("FAIL hold_blk2 got gnt=%b q=%h exp 0000/77", gnt2, q2); end
    tick();
    req2 = '0;
    checks++; if (gnt2 !== 4'b0010 || q2 !== 8'h5A || qv2 !== 1'b1) begin errors++; $display("FAIL hold_release got gnt=%b q=%h qv=%b exp 0010/5a/1", gnt2, q2, qv2); end
    tick(); tick();
  endtask

  task automatic test_reset_mid_hold();
    // ptr is 2
    wd2 = 32'h003C5A00; req2 = 4'b0100;
    tick();
    checks++; if (busy2 !== 1'b1 || q2 !== 8'h3C) begin errors++; $display("FAIL midhold_pre got busy=%b q=%h exp 1/3c", busy2, q2); end
    rst = 1'b1; req2 = '0;
    tick();
    rst = 1'b0;
    checks++; if (busy2 !== 1'b0 || q2 !== 8'h00 || own2 !== 2'd0) begin errors++; $display("FAIL midhold_rst got busy=%b q=%h own=%0d exp 0/00/0", busy2, q2, own2); end
    // ptr back at 0: requester 1 must beat requester 3
    req2 = 4'b1010;
    tick();
    req2 = '0;
    checks++; if (gnt2 !== 4'b0010 || q2 !== 8'h5A) begin errors++; $display("FAIL midhold_ptr got gnt=%b q=%h exp 0010/5a", gnt2, q2); end
`ifdef SHARED_REG_PARITY_EN
    checks++; if (qpar2 !== 1'b0 || perr2 !== 1'b0) begin errors++; $display("FAIL par_clean got qpar=%b perr=%b exp 0/0", qpar2, perr2); end
    force u_h2.q_par = 1'b1;
    chk2 = 1'b1;
    tick();
    chk2 = 1'b0;
    release u_h2.q_par;
    tick();
    checks++; if (perr2 !== 1'b1) begin errors++; $display("FAIL par_err_set got %b exp 1", perr2); end
    tick();
    checks++; if (perr2 !== 1'b1) begin errors++; $display("FAIL par_err_sticky got %b exp 1", perr2); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (perr2 !== 1'b0) begin errors++; $display("FAIL par_err_clear got %b exp 0", perr2); end
`endif
    tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [7:0] exp_q [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    wd0 = 32'h13121110; req0 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (gnt0 !== exp_g[i] || q0 !== exp_q[i] || qv0 !== 1'b1) begin errors++; $display("FAIL rr_step%0d got gnt=%b q=%h qv=%b exp %b/%h/1", i, gnt0, q0, qv0, exp_g[i], exp_q[i]); end
    end
    req0 = '0;
    tick();
    checks++; if (gnt0 !== 4'b0000 || qv0 !== 1'b0 || q0 !== 8'h10 || busy0 !== 1'b0) begin errors++; $display("FAIL rr_idle got gnt=%b qv=%b q=%h busy=%b exp 0000/0/10/0", gnt0, qv0, q0, busy0); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_writer();
    test_wrap();
    test_hold_block();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
